// File: rtl/imm_extender.sv
// rtl/imm_extender.sv - registered immediate-extension stage with optional prefix words
// Optional prefix support is enabled by defining IMMEXT_PREFIX_EN.
module imm_extender #(
  parameter int DATA_W   = 16,
  parameter int FIELD_W  = 4,
  parameter int PREFIX_W = 12
) (
  input  logic              Clock,
  input  logic              ResetN,
  input  logic              Flush,
  input  logic              InValid,
  output logic              InReady,
  input  logic [DATA_W-1:0] In,
  input  logic [1:0]        Mode,
  output logic              OutValid,
  input  logic              OutReady,
  output logic [DATA_W-1:0] Out,
  output logic              PrefixPending
);

  localparam logic [1:0] MODE_ZERO   = 2'b00;
  localparam logic [1:0] MODE_SIGN   = 2'b01;
  localparam logic [1:0] MODE_SHIFT  = 2'b10;
  localparam logic [1:0] MODE_PREFIX = 2'b11;

  logic               accept;
  logic               produce;
  logic [DATA_W-1:0]  result;
  logic [FIELD_W-1:0] field;
  logic [DATA_W-1:0]  field_zext;
  logic [DATA_W-1:0]  field_sext;
  logic               unused_in;

  // Mode 11 only reaches here when prefixes are disabled, where it acts as sign-extend.
  function automatic logic [DATA_W-1:0] extend(input logic [DATA_W-1:0] zv,
                                               input logic [DATA_W-1:0] sv,
                                               input logic [1:0]        m);
    case (m)
      MODE_ZERO:  return zv;
      MODE_SIGN:  return sv;
      MODE_SHIFT: return sv << 1;
      default:    return sv;
    endcase
  endfunction

  assign InReady    = !OutValid || OutReady;
  assign accept     = InValid && InReady;
  assign field      = In[FIELD_W-1:0];
  assign field_zext = DATA_W'(field);
  assign field_sext = DATA_W'($signed(field));
  assign unused_in  = ^In;

`ifdef IMMEXT_PREFIX_EN
  localparam int WIDE_W = FIELD_W + PREFIX_W;

  typedef enum logic {
    IDLE     = 1'b0,
    PREFIXED = 1'b1
  } state_t;

  state_t              state;
  state_t              state_next;
  logic [PREFIX_W-1:0] prefix_q;
  logic [WIDE_W-1:0]   wide_field;

  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      state    <= IDLE;
      prefix_q <= '0;
    end else if (Flush) begin
      state <= IDLE;
    end else begin
      state <= state_next;
      if (accept && Mode == MODE_PREFIX) begin
        prefix_q <= In[PREFIX_W-1:0];
      end
    end
  end

  always_comb begin
    state_next = state;
    if (accept) begin
      state_next = (Mode == MODE_PREFIX) ? PREFIXED : IDLE;
    end
  end

  // Prefixed words extend from the prefix MSB, so the whole concatenation is sign-cast.
  always_comb begin
    PrefixPending = (state == PREFIXED);
    wide_field    = {prefix_q, field};
    produce       = accept && (Mode != MODE_PREFIX);
    if (state == PREFIXED) begin
      result = extend(DATA_W'(wide_field), DATA_W'($signed(wide_field)), Mode);
    end else begin
      result = extend(field_zext, field_sext, Mode);
    end
  end
`else
  logic [PREFIX_W-1:0] unused_prefix_bits;

  assign unused_prefix_bits = In[PREFIX_W-1:0];

  always_comb begin
    PrefixPending = 1'b0;
    produce       = accept;
    result        = extend(field_zext, field_sext, Mode);
  end
`endif

  // Flush drops the valid bit but leaves the last operand value in place.
  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      OutValid <= 1'b0;
      Out      <= '0;
    end else if (Flush) begin
      OutValid <= 1'b0;
    end else if (produce) begin
      OutValid <= 1'b1;
      Out      <= result;
    end else if (OutReady) begin
      OutValid <= 1'b0;
    end
  end

endmodule
